// File: rtl/issue_slot_freelist.sv
// Issue-queue slot free list: one allocation per cycle, mask-based returns.
// Define ISSUE_SLOT_FREELIST_RR_EN for round-robin selection; otherwise fixed priority from slot 0.
module issue_slot_freelist #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             alloc_req,
  output logic             alloc_gnt,
  output logic [N-1:0]     alloc_onehot,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic [N-1:0]     free_mask,
  output logic [IDX_W:0]   free_count,
  output logic             full,
  output logic             empty,
  output logic             err_dbl_free
);

  // Handshake: alloc_req is a per-cycle request with no hold requirement.
  // alloc_gnt is combinational from registered state in the same cycle. The slot
  // named by alloc_onehot/alloc_idx is owned from the next rising edge; when
  // alloc_gnt is low, alloc_onehot and alloc_idx are 0 and no state changes.

  logic [N-1:0]     free_vec_q, free_vec_d;
  logic [IDX_W:0]   free_count_q, free_count_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [N-1:0]     newly_freed;
  logic [IDX_W:0]   pop;

`ifdef ISSUE_SLOT_FREELIST_RR_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  assign base = rr_ptr_q;
`else
  assign base = '0;
`endif

  // Scan from the highest offset down so the lowest offset from base wins.
  // The index sum wraps naturally because N is a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand = base + IDX_W'(off);
      if (free_vec_q[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    alloc_gnt    = alloc_req & sel_found;
    alloc_onehot = '0;
    alloc_idx    = '0;
    if (alloc_gnt) begin
      alloc_onehot[sel_idx] = 1'b1;
      alloc_idx             = sel_idx;
    end
  end

  // Only slots that are actually in use count toward a return.
  always_comb begin
    newly_freed = free_mask & ~free_vec_q;
    pop         = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + (IDX_W + 1)'(newly_freed[i]);
    end
  end

  always_comb begin
    free_vec_d   = (free_vec_q & ~alloc_onehot) | free_mask;
    free_count_d = free_count_q - {{IDX_W{1'b0}}, alloc_gnt} + pop;
    err_d        = err_q | (|(free_mask & free_vec_q));
  end

`ifdef ISSUE_SLOT_FREELIST_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (alloc_gnt) begin
      rr_ptr_d = sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      free_vec_q   <= '1;
      free_count_q <= (IDX_W + 1)'(N);
      err_q        <= 1'b0;
    end else begin
      free_vec_q   <= free_vec_d;
      free_count_q <= free_count_d;
      err_q        <= err_d;
    end
  end

  assign free_count   = free_count_q;
  assign full         = (free_count_q == '0);
  assign empty        = (free_count_q == (IDX_W + 1)'(N));
  assign err_dbl_free = err_q;

endmodule
